// File: rtl/ham_pkg.sv
// ham_pkg: shared types for the Hamming(7,4) serial receive path
package ham_pkg;
  localparam int CODE_W = 7;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_t;
  typedef logic [CODE_W-1:0] ham_code_t;
endpackage

// File: rtl/ham_serial_rx_sync_2ff.sv
// sync_2ff: two-flop synchronizer with a parameterised reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ham_serial_rx.sv
// ham_serial_rx: UART-style deserializer delivering 7-bit codewords on valid/ready
module ham_serial_rx
  import ham_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_i,
  output ham_code_t        code_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             framing_err_o,
  output logic             overrun_o,
  output logic [CNT_W-1:0] frame_cnt_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HMID = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_t state, state_d;
  logic [CW-1:0] clk_cnt, cnt_d;
  logic [2:0] bit_idx, idx_d;
  ham_code_t shreg, sh_d;
  logic rx_s, stop_ok, stop_bad, deliver_q;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx_i), .q(rx_s));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      clk_cnt <= cnt_d;
      bit_idx <= idx_d;
      shreg   <= sh_d;
    end
  end
  always_comb begin
    state_d  = state;
    cnt_d    = clk_cnt + CW'(1);
    idx_d    = bit_idx;
    sh_d     = shreg;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (clk_cnt == HMID) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (clk_cnt == LAST) begin
        cnt_d         = '0;
        sh_d[bit_idx] = rx_s;
        idx_d         = bit_idx + 3'd1;
        state_d       = (bit_idx == 3'd6) ? STOP : DATA;
      end
      STOP: if (clk_cnt == LAST) begin
        cnt_d    = '0;
        stop_ok  = rx_s;
        stop_bad = !rx_s;
        state_d  = rx_s ? IDLE : WAIT_HI;
      end
      WAIT_HI: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : WAIT_HI;
      end
      default: state_d = IDLE;
    endcase
  end
  // a held, unconsumed word always beats a newly completed frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_o        <= '0;
      valid_o       <= 1'b0;
      framing_err_o <= 1'b0;
      overrun_o     <= 1'b0;
      frame_cnt_o   <= '0;
      deliver_q     <= 1'b0;
    end else begin
      deliver_q     <= stop_ok;
      framing_err_o <= stop_bad;
      overrun_o     <= deliver_q && valid_o && !ready_i;
      if (deliver_q && (!valid_o || ready_i)) begin
        code_o      <= shreg;
        valid_o     <= 1'b1;
        frame_cnt_o <= frame_cnt_o + CNT_W'(1);
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ham_serial_rx.sv
// tb_ham_serial_rx: directed and randomized frames checked against a queue-based model
module tb_ham_serial_rx;
  localparam int CPB = 4;
  logic clk = 1'b0, rst_n, rx_i, ready_i;
  logic [6:0] code_o;
  logic valid_o, framing_err_o, overrun_o;
  logic [7:0] frame_cnt_o;
  int total = 0, bad = 0;
  int nferr = 0, novr = 0, vcyc = 0;
  bit seen_ff = 0;
  logic [6:0] rxq[$];
  logic [6:0] expq[$];
  ham_serial_rx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .code_o(code_o), .valid_o(valid_o),
    .ready_i(ready_i), .framing_err_o(framing_err_o), .overrun_o(overrun_o),
    .frame_cnt_o(frame_cnt_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && ready_i) rxq.push_back(code_o);
      if (valid_o) vcyc++;
      if (framing_err_o) nferr++;
      if (overrun_o) novr++;
      if (frame_cnt_o == 8'hFF) seen_ff = 1;
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [6:0] c, input logic stop);
    logic [8:0] bits;
    bits = {stop, c, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rx_i = bits[i];
      tick(CPB);
    end
  endtask
  function automatic logic [2:0] syn(input logic [6:0] c);
    logic [2:0] s;
    s = '0;
    for (int p = 1; p <= 7; p++) if (c[p-1]) s ^= 3'(p);
    return s;
  endfunction
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    logic [2:0] s;
    c = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    s = syn(c);
    c[0] = s[0];
    c[1] = s[1];
    c[3] = s[2];
    return c;
  endfunction
  initial begin
    int f0, o0, v0, n0, ecnt, errs;
    logic [6:0] w;
    logic [8:0] bits;
    logic st;
    rst_n = 1'b0;
    rx_i = 1'b1;
    ready_i = 1'b1;
    tick(3);
    chk("rst_code", code_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ferr", framing_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_cnt", frame_cnt_o, 0);
    rst_n = 1'b1;
    tick(4);
    // T1
    v0 = vcyc; n0 = rxq.size();
    send(7'b1011010, 1'b1);
    tick(8);
    chk("t1_rxn", rxq.size(), n0 + 1);
    chk("t1_code", rxq[$], 7'h5A);
    chk("t1_vcyc", vcyc - v0, 1);
    chk("t1_cnt", frame_cnt_o, 1);
    chk("t1_err", nferr + novr, 0);
    ecnt = 1;
    // T2
    ready_i = 1'b0;
    o0 = novr; n0 = rxq.size();
    send(7'h33, 1'b1);
    send(7'h4C, 1'b1);
    tick(8);
    chk("t2_valid", valid_o, 1);
    chk("t2_code", code_o, 7'h33);
    chk("t2_ovr", novr - o0, 1);
    ecnt++;
    chk("t2_cnt", frame_cnt_o, ecnt);
    ready_i = 1'b1;
    tick(2);
    chk("t2_valid_clr", valid_o, 0);
    chk("t2_rxn", rxq.size(), n0 + 1);
    chk("t2_consumed", rxq[$], 7'h33);
    // T3
    f0 = nferr; n0 = rxq.size();
    send(7'h7F, 1'b0);
    tick(20 * CPB);
    chk("t3_ferr", nferr - f0, 1);
    chk("t3_valid", valid_o, 0);
    rx_i = 1'b1;
    tick(3 * CPB);
    send(7'h01, 1'b1);
    tick(8);
    chk("t3_rxn", rxq.size(), n0 + 1);
    chk("t3_code", rxq[$], 7'h01);
    chk("t3_ferr_once", nferr - f0, 1);
    ecnt++;
    chk("t3_cnt", frame_cnt_o, ecnt);
    // T4
    f0 = nferr; v0 = vcyc; n0 = rxq.size();
    rx_i = 1'b0;
    tick(1);
    rx_i = 1'b1;
    tick(20);
    chk("t4_vcyc", vcyc - v0, 0);
    chk("t4_ferr", nferr - f0, 0);
    chk("t4_rxn", rxq.size(), n0);
    // T5
    bits = {1'b1, 7'h55, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx_i = bits[i];
      tick(CPB);
    end
    rx_i = bits[4];
    tick(1);
    rst_n = 1'b0;
    tick(2);
    rx_i = 1'b1;
    rst_n = 1'b1;
    n0 = rxq.size(); f0 = nferr;
    tick(6 * CPB);
    chk("t5_valid", valid_o, 0);
    chk("t5_cnt_rst", frame_cnt_o, 0);
    chk("t5_code_rst", code_o, 0);
    send(7'h2A, 1'b1);
    tick(8);
    chk("t5_rxn", rxq.size(), n0 + 1);
    chk("t5_code", rxq[$], 7'h2A);
    chk("t5_cnt", frame_cnt_o, 1);
    chk("t5_ferr", nferr - f0, 0);
    // T6
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    expq.delete();
    n0 = rxq.size(); f0 = nferr; o0 = novr; seen_ff = 0;
    for (int k = 0; k < 256; k++) begin
      w = enc(4'($urandom_range(0, 15)));
      expq.push_back(w);
      send(w, 1'b1);
    end
    tick(8);
    chk("t6_rxn", rxq.size() - n0, 256);
    errs = 0;
    for (int k = 0; k < 256 && n0 + k < rxq.size(); k++) begin
      chk($sformatf("t6_word%0d", k), rxq[n0+k], expq[k]);
      chk($sformatf("t6_syn%0d", k), syn(rxq[n0+k]), 0);
    end
    chk("t6_cnt_wrap", frame_cnt_o, 0);
    chk("t6_seen_ff", seen_ff, 1);
    chk("t6_errs", (nferr - f0) + (novr - o0), 0);
    // T7: random stop bits
    expq.delete();
    n0 = rxq.size(); f0 = nferr;
    for (int k = 0; k < 24; k++) begin
      w = 7'($urandom_range(0, 127));
      st = ($urandom_range(0, 3) != 0);
      if (st) expq.push_back(w);
      else errs++;
      send(w, st);
      rx_i = 1'b1;
      tick(2 * CPB);
    end
    tick(8);
    chk("t7_rxn", rxq.size() - n0, expq.size());
    chk("t7_ferr", nferr - f0, errs);
    for (int k = 0; k < expq.size() && n0 + k < rxq.size(); k++)
      chk($sformatf("t7_word%0d", k), rxq[n0+k], expq[k]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
